encoder_sample_ctrl: RTL and testbench

Sequencer for the encoder measurement datapath.
- Runs a fixed gate window and latches the position counter at the end of each window.
- Computes speed as position delta per window and raises a sample interrupt.
- Services clear requests from the Avalon register block and drives the counter clear.
- Sits between the raw quadrature position counter and the register block; its step/speed outputs feed the register block's read mux.

---
 rtl/encoder_pkg.sv | 18 +
 rtl/encoder_gate_timer.sv | 38 +++
 rtl/encoder_sample_ctrl.sv | 170 +++++++++++++++++
 tb/tb_encoder_sample_ctrl.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/encoder_pkg.sv
// Shared types and constants for the encoder measurement sequencer.
package encoder_pkg;

    localparam int unsigned CntWDefault = 32;
    localparam int unsigned GateCntW    = 24;

    localparam logic [7:0] AddrCtrl  = 8'h00;
    localparam logic [7:0] AddrStep  = 8'h01;
    localparam logic [7:0] AddrSpeed = 8'h02;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StLatch,
        StClr
    } enc_state_e;

endpackage

// File: rtl/encoder_gate_timer.sv
// Measurement-window counter: start loads zero and runs, stop loads zero and halts.
module encoder_gate_timer
    import encoder_pkg::*;
#(
    parameter int unsigned GATE_CYCLES = 50000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                stop,
    output logic                tc,
    output logic [GateCntW-1:0] gate_cnt
);

    localparam logic [GateCntW-1:0] LastCnt = GateCntW'(GATE_CYCLES - 1);

    logic                run_q;
    logic [GateCntW-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            run_q <= 1'b0;
            cnt_q <= '0;
        end else if (stop) begin
            run_q <= 1'b0;
            cnt_q <= '0;
        end else if (start) begin
            run_q <= 1'b1;
            cnt_q <= '0;
        end else if (run_q) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign tc       = run_q && (cnt_q == LastCnt);
    assign gate_cnt = cnt_q;

endmodule

// File: rtl/encoder_sample_ctrl.sv
// Encoder sampling sequencer: gated position latch, speed delta, sample irq, counter clear.
// Optional ENCODER_SPEED_AVG_EN averages speed over the last four windows.
module encoder_sample_ctrl
    import encoder_pkg::*;
#(
    parameter int unsigned GATE_CYCLES = 50000,
    parameter int unsigned CNT_W       = CntWDefault
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             clear,
    input  logic [CNT_W-1:0] enc_count,
    input  logic             irq_ack,
    output logic             cnt_clr,
    output logic [CNT_W-1:0] step,
    output logic [CNT_W-1:0] speed,
    output logic             sample_valid,
    output logic             irq,
    output logic             busy
);

    enc_state_e          state_q;
    logic [CNT_W-1:0]    prev_q;
    logic [CNT_W-1:0]    step_q;
    logic [CNT_W-1:0]    speed_q;
    logic                cnt_clr_q;
    logic                sample_valid_q;
    logic                irq_q;
    logic                busy_q;

    logic                tmr_start;
    logic                tmr_stop;
    logic                tmr_tc;
    logic [GateCntW-1:0] gate_cnt;
    logic                unused_gate_cnt;

    logic [CNT_W-1:0]    raw_delta;
    logic [CNT_W-1:0]    latch_speed;

    encoder_gate_timer #(
        .GATE_CYCLES (GATE_CYCLES)
    ) u_gate_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (tmr_start),
        .stop     (tmr_stop),
        .tc       (tmr_tc),
        .gate_cnt (gate_cnt)
    );

    assign unused_gate_cnt = ^gate_cnt;

    // Timer runs exactly while the FSM sits in RUN.
    always_comb begin
        tmr_start = 1'b0;
        tmr_stop  = 1'b0;
        if (clear) begin
            tmr_stop = 1'b1;
        end else begin
            case (state_q)
                StIdle, StLatch, StClr: tmr_start = enable;
                StRun:                  tmr_stop  = tmr_tc || !enable;
                default:                tmr_stop  = 1'b1;
            endcase
        end
    end

    // Modulo subtraction gives the correct signed delta across counter wrap.
    assign raw_delta = enc_count - prev_q;

`ifdef ENCODER_SPEED_AVG_EN
    logic [CNT_W-1:0] hist0_q, hist1_q, hist2_q;
    logic [CNT_W+1:0] avg_sum;
    logic [1:0]       unused_avg_lsb;

    function automatic logic [CNT_W+1:0] sext2(input logic [CNT_W-1:0] v);
        return {{2{v[CNT_W-1]}}, v};
    endfunction

    // Newest delta plus three prior ones; bits [CNT_W+1:2] are the arithmetic >>2.
    assign avg_sum        = sext2(raw_delta) + sext2(hist0_q) + sext2(hist1_q) + sext2(hist2_q);
    assign latch_speed    = avg_sum[CNT_W+1:2];
    assign unused_avg_lsb = avg_sum[1:0];

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            hist0_q <= '0;
            hist1_q <= '0;
            hist2_q <= '0;
        end else if (state_q == StLatch) begin
            hist0_q <= raw_delta;
            hist1_q <= hist0_q;
            hist2_q <= hist1_q;
        end
    end
`else
    assign latch_speed = raw_delta;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= StIdle;
            prev_q         <= '0;
            step_q         <= '0;
            speed_q        <= '0;
            cnt_clr_q      <= 1'b0;
            sample_valid_q <= 1'b0;
            irq_q          <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            cnt_clr_q      <= 1'b0;
            sample_valid_q <= 1'b0;
            if (irq_ack) begin
                irq_q <= 1'b0;
            end
            if (clear) begin
                state_q   <= StClr;
                cnt_clr_q <= 1'b1;
                step_q    <= '0;
                speed_q   <= '0;
                prev_q    <= '0;
                busy_q    <= 1'b1;
            end else begin
                case (state_q)
                    StIdle: begin
                        if (enable) begin
                            state_q <= StRun;
                            prev_q  <= enc_count;
                            busy_q  <= 1'b1;
                        end
                    end
                    StRun: begin
                        if (tmr_tc) begin
                            state_q <= StLatch;
                        end else if (!enable) begin
                            state_q <= StIdle;
                            busy_q  <= 1'b0;
                        end
                    end
                    StLatch: begin
                        step_q         <= enc_count;
                        speed_q        <= latch_speed;
                        prev_q         <= enc_count;
                        sample_valid_q <= 1'b1;
                        irq_q          <= 1'b1;
                        state_q        <= enable ? StRun : StIdle;
                        busy_q         <= enable;
                    end
                    StClr: begin
                        state_q <= enable ? StRun : StIdle;
                        busy_q  <= enable;
                    end
                    default: begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign cnt_clr      = cnt_clr_q;
    assign step         = step_q;
    assign speed        = speed_q;
    assign sample_valid = sample_valid_q;
    assign irq          = irq_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_encoder_sample_ctrl.sv
// Directed bench for encoder_sample_ctrl with GATE_CYCLES=8; honours ENCODER_SPEED_AVG_EN.
module tb_encoder_sample_ctrl;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic        clear;
    logic [31:0] enc_count;
    logic        irq_ack;
    logic        cnt_clr;
    logic [31:0] step;
    logic [31:0] speed;
    logic        sample_valid;
    logic        irq;
    logic        busy;

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] prev_m;
    logic [31:0] last_spd;
    logic [31:0] h0, h1, h2;

    encoder_sample_ctrl #(
        .GATE_CYCLES (8),
        .CNT_W       (32)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .clear        (clear),
        .enc_count    (enc_count),
        .irq_ack      (irq_ack),
        .cnt_clr      (cnt_clr),
        .step         (step),
        .speed        (speed),
        .sample_valid (sample_valid),
        .irq          (irq),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    task automatic model_clear();
        prev_m = 32'h0;
        h0 = 32'h0;
        h1 = 32'h0;
        h2 = 32'h0;
    endtask

    // Expected speed for a window whose raw delta is raw.
    task automatic model_sample(input logic [31:0] raw, output logic [31:0] exp);
`ifdef ENCODER_SPEED_AVG_EN
        logic [33:0] s;
        s = {{2{raw[31]}}, raw} + {{2{h0[31]}}, h0} + {{2{h1[31]}}, h1} + {{2{h2[31]}}, h2};
        exp = s[33:2];
        h2 = h1;
        h1 = h0;
        h0 = raw;
`else
        exp = raw;
`endif
    endtask

    // Starts with the FSM in RUN at gate count 0; ends on the sample_valid cycle.
    task automatic window(input logic [31:0] val, input string tag);
        logic [31:0] exp_spd;
        enc_count = val;
        tick(8);
        check({tag, "_pre_valid"}, sample_valid, 0);
        tick(1);
        check({tag, "_valid"}, sample_valid, 1);
        model_sample(val - prev_m, exp_spd);
        check({tag, "_step"}, step, val);
        check({tag, "_speed"}, speed, exp_spd);
        prev_m   = val;
        last_spd = exp_spd;
    endtask

    initial begin
        logic [31:0] exp_spd;
        rst_n     = 1'b0;
        enable    = 1'b0;
        clear     = 1'b0;
        enc_count = 32'h0;
        irq_ack   = 1'b0;
        model_clear();
        last_spd = 32'h0;
        tick(2);
        check("rst_step", step, 0);
        check("rst_speed", speed, 0);
        check("rst_valid", sample_valid, 0);
        check("rst_irq", irq, 0);
        check("rst_busy", busy, 0);
        check("rst_cnt_clr", cnt_clr, 0);

        rst_n = 1'b1;
        tick(1);
        check("idle_busy", busy, 0);

        // Basic periodic sampling, +3 per window.
        enable = 1'b1;
        tick(1);
        check("run_busy", busy, 1);
        check("irq_before_sample", irq, 0);
        window(32'd3, "w3");
        check("irq_after_first", irq, 1);
        tick(1);
        check("valid_single_cycle", sample_valid, 0);
        enc_count = 32'd6;
        tick(7);
        check("w6_pre_valid", sample_valid, 0);
        tick(1);
        check("w6_valid", sample_valid, 1);
        model_sample(32'd3, exp_spd);
        check("w6_step", step, 6);
        check("w6_speed", speed, exp_spd);
        prev_m = 32'd6;
        window(32'd9, "w9");

        // Signed wrap across 0x7FFFFFFF.
        window(32'h7FFF_FFFE, "wrap_a");
        window(32'h8000_0004, "wrap_b");
        check("wrap_raw_delta", speed, (32'h8000_0004 - 32'h7FFF_FFFE) == 32'd6 ? last_spd : 32'hDEAD);

        // Decreasing position.
        window(32'h7FFF_FFFA, "dec_a");
        window(32'h7FFF_FFF0, "dec_b");

        // irq acknowledge, then set and ack on the same edge.
        irq_ack = 1'b1;
        tick(1);
        irq_ack = 1'b0;
        check("irq_ack_clears", irq, 0);
        enc_count = 32'h7FFF_FFE6;
        tick(7);
        check("irq_win_pre_valid", sample_valid, 0);
        irq_ack = 1'b1;
        tick(1);
        check("irq_win_valid", sample_valid, 1);
        check("irq_set_beats_ack", irq, 1);
        model_sample(32'h7FFF_FFE6 - prev_m, exp_spd);
        check("irq_win_speed", speed, exp_spd);
        prev_m = 32'h7FFF_FFE6;
        tick(1);
        irq_ack = 1'b0;
        check("irq_late_ack", irq, 0);

        // Clear lands on the LATCH cycle: sample discarded.
        tick(7);
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
        check("clr_latch_cnt_clr", cnt_clr, 1);
        check("clr_latch_no_valid", sample_valid, 0);
        check("clr_latch_step", step, 0);
        check("clr_latch_speed", speed, 0);
        check("clr_latch_no_irq", irq, 0);
        check("clr_busy", busy, 1);
        model_clear();
        tick(1);
        check("clr_exit_cnt_clr", cnt_clr, 0);
        check("clr_exit_valid", sample_valid, 0);
        window(32'd5, "after_clr");
        check("after_clr_irq", irq, 1);

        // Back-to-back clear keeps cnt_clr high an extra cycle.
        clear = 1'b1;
        tick(1);
        check("dbl_clr_1", cnt_clr, 1);
        tick(1);
        clear = 1'b0;
        check("dbl_clr_2", cnt_clr, 1);
        tick(1);
        check("dbl_clr_exit", cnt_clr, 0);
        model_clear();

        // Deltas 4, 8, 12, 16 (averaged build: 1, 3, 6, 10).
        window(32'd4, "avg_1");
        window(32'd12, "avg_2");
        window(32'd24, "avg_3");
        window(32'd40, "avg_4");
`ifdef ENCODER_SPEED_AVG_EN
        check("avg_final", speed, 32'd10);
`else
        check("raw_final", speed, 32'd16);
`endif

        // Enable drop mid-window: back to IDLE, results hold.
        tick(4);
        enable = 1'b0;
        tick(1);
        check("drop_busy", busy, 0);
        check("drop_step_hold", step, 40);
        check("drop_speed_hold", speed, last_spd);
        check("drop_no_valid", sample_valid, 0);
        tick(1);
        check("drop_idle_busy", busy, 0);

        // Reset mid-window.
        enable    = 1'b1;
        enc_count = 32'd100;
        tick(4);
        check("mid_busy", busy, 1);
        rst_n = 1'b0;
        tick(1);
        check("mid_rst_step", step, 0);
        check("mid_rst_speed", speed, 0);
        check("mid_rst_valid", sample_valid, 0);
        check("mid_rst_irq", irq, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_cnt_clr", cnt_clr, 0);
        rst_n  = 1'b1;
        enable = 1'b0;
        tick(2);
        check("post_rst_busy", busy, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
